// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types for the clk_div_gen clock-enable generator.
// Counter fields are CNT_MAX wide; clk_div_gen supports CNT_W up to CNT_MAX.
package clk_div_pkg;

  localparam int CNT_MAX = 16;

  typedef logic [CNT_MAX-1:0] cnt_t;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  typedef struct packed {
    cnt_t ratio;
    cnt_t duty;
    cnt_t phase;
  } ch_cfg_t;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel -- counter, reload on start,
// wrap detection and registered clk_en/clk_div decode.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter ch_cfg_t INIT = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    run_d,
  input  logic    start,
  input  logic    cfg_wr,
  input  ch_cfg_t cfg_new,
  output logic    wrap,
  output logic    clk_en,
  output logic    clk_div
);

  ch_cfg_t cfg_q;
  ch_cfg_t cfg_d;
  cnt_t    cnt;
  cnt_t    cnt_d;
  cnt_t    reload;

  // Outputs decode the next count so they line up with the cycle it holds.
  always_comb begin
    cfg_d  = cfg_wr ? cfg_new : cfg_q;
    wrap   = (cnt >= cfg_q.ratio - cnt_t'(1));
    reload = '0;
    if (cfg_d.phase != '0)
      reload = cfg_d.ratio - cfg_d.phase;
    cnt_d = cnt + cnt_t'(1);
    if (!run_d || start)
      cnt_d = reload;
    else if (wrap)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= INIT;
      cnt     <= '0;
      clk_en  <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      cnt     <= cnt_d;
      clk_en  <= run_d && (cnt_d == '0);
      clk_div <= run_d && (cnt_d < cfg_d.duty);
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: N-channel clock-enable / divided-clock generator.
// Runtime config port built only with CLK_DIV_GEN_DYN_CFG_EN defined.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 10,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_RATIO = {NUM_CH{10'd2}},
  parameter logic [NUM_CH*CNT_W-1:0] INIT_DUTY  = {NUM_CH{10'd1}},
  parameter logic [NUM_CH*CNT_W-1:0] INIT_PHASE = {NUM_CH{10'd0}}
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      pll_lock,
  input  logic                      resync,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_ratio,
  input  logic [CNT_W-1:0]          cfg_duty,
  input  logic [CNT_W-1:0]          cfg_phase,
  output logic                      cfg_err,
  output logic                      locked,
  output logic [NUM_CH-1:0]         clk_en,
  output logic [NUM_CH-1:0]         clk_div
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LCK_MAX = LCK_W'(LOCK_CYCLES);

  logic [1:0]       lock_sync;
  logic             lock_s;
  logic [LCK_W-1:0] lock_cnt;
  logic [LCK_W-1:0] lock_cnt_d;
  state_t           state;
  state_t           state_d;
  logic             run_d;
  logic             start;

  ch_cfg_t          cfg_new;
  logic [NUM_CH-1:0] cfg_wr;
  logic [NUM_CH-1:0] wrap;

  assign lock_s = lock_sync[1];

  always_comb begin
    lock_cnt_d = lock_cnt;
    if (!lock_s)
      lock_cnt_d = '0;
    else if (lock_cnt != LCK_MAX)
      lock_cnt_d = lock_cnt + LCK_W'(1);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      WAIT_LOCK: if (lock_cnt_d == LCK_MAX) state_d = RUN;
      RUN:       if (!lock_s) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_sync <= '0;
      lock_cnt  <= '0;
      state     <= WAIT_LOCK;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
      lock_cnt  <= lock_cnt_d;
      state     <= state_d;
    end
  end

  assign locked = (state == RUN);
  assign run_d  = (state_d == RUN);
  assign start  = run_d && ((state == WAIT_LOCK) || resync);

`ifdef CLK_DIV_GEN_DYN_CFG_EN
  logic            pend;
  logic            fire;
  logic            req_ok;
  logic            commit;
  logic [CH_W-1:0] sh_ch;
  ch_cfg_t         sh_cfg;

  assign cfg_ready = !pend;
  assign fire      = cfg_valid && cfg_ready;
  assign req_ok    = (cfg_ratio != '0)
                  && (cfg_duty != '0)
                  && (cfg_duty <= cfg_ratio)
                  && (cfg_phase < cfg_ratio)
                  && (int'(cfg_ch) < NUM_CH);
  // Idle channels commit at once; running ones wait for their wrap.
  assign commit    = pend
                  && ((state == WAIT_LOCK) || wrap[sh_ch]);
  assign cfg_new   = sh_cfg;

  always_comb begin
    cfg_wr = '0;
    for (int i = 0; i < NUM_CH; i++)
      cfg_wr[i] = commit && (int'(sh_ch) == i);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend    <= 1'b0;
      sh_ch   <= '0;
      sh_cfg  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= fire && !req_ok;
      if (commit)
        pend <= 1'b0;
      if (fire && req_ok) begin
        pend   <= 1'b1;
        sh_ch  <= cfg_ch;
        sh_cfg <= '{
          ratio: cnt_t'(cfg_ratio),
          duty:  cnt_t'(cfg_duty),
          phase: cnt_t'(cfg_phase)
        };
      end
    end
  end
`else
  logic unused_cfg;

  assign cfg_ready  = 1'b0;
  assign cfg_err    = 1'b0;
  assign cfg_wr     = '0;
  assign cfg_new    = '0;
  assign unused_cfg = ^{cfg_valid, cfg_ch, cfg_ratio,
                        cfg_duty, cfg_phase, wrap};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam ch_cfg_t INIT_I = '{
      ratio: cnt_t'(INIT_RATIO[i*CNT_W +: CNT_W]),
      duty:  cnt_t'(INIT_DUTY[i*CNT_W +: CNT_W]),
      phase: cnt_t'(INIT_PHASE[i*CNT_W +: CNT_W])
    };

    clk_div_ch #(
      .INIT (INIT_I)
    ) u_ch (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .run_d   (run_d),
      .start   (start),
      .cfg_wr  (cfg_wr[i]),
      .cfg_new (cfg_new),
      .wrap    (wrap[i]),
      .clk_en  (clk_en[i]),
      .clk_div (clk_div[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: vector table, directed corner sequences and a
// randomized run checked against a period/anchor reference model.
module tb_clk_div_gen;

  localparam int NCH = 3;
  localparam int CW  = 10;
  localparam int LCK = 16;
`ifdef CLK_DIV_GEN_DYN_CFG_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          resync = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_ratio = '0;
  logic [CW-1:0] cfg_duty = '0;
  logic [CW-1:0] cfg_phase = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic          locked;
  logic [NCH-1:0] clk_en;
  logic [NCH-1:0] clk_div;

  always #5 clk = ~clk;

  clk_div_gen #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .LOCK_CYCLES (LCK),
    .INIT_RATIO  ({10'd1, 10'd4, 10'd5}),
    .INIT_DUTY   ({10'd1, 10'd1, 10'd2}),
    .INIT_PHASE  ({10'd0, 10'd3, 10'd0})
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .pll_lock  (pll_lock),
    .resync    (resync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_ratio (cfg_ratio),
    .cfg_duty  (cfg_duty),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .locked    (locked),
    .clk_en    (clk_en),
    .clk_div   (clk_div)
  );

  int nvec = 0;
  int nerr = 0;
  int n = 0;

  // Reference model: each channel runs from an anchor cycle A with
  // position (t - A) mod ratio; lock state comes from run lengths.
  int m_r[NCH] = '{5, 4, 1};
  int m_d[NCH] = '{2, 1, 1};
  int m_p[NCH] = '{0, 3, 0};
  int m_a[NCH] = '{0, 0, 0};
  bit m_lk = 1'b0;
  bit m_pend = 1'b0;
  bit m_err = 1'b0;
  int m_sch, m_sr, m_sd, m_sp;
  int rl = 0;
  int hist[$];

  typedef struct {
    logic           rs;
    logic [NCH-1:0] en;
    logic [NCH-1:0] dv;
  } vec_t;
  vec_t tab[17];

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)",
               nm, act, exp, n);
    end
  endtask

  function automatic int pos(int i, int t);
    int x;
    x = (t - m_a[i]) % m_r[i];
    if (x < 0) x += m_r[i];
    return x;
  endfunction

  task automatic step();
    bit lk_new, fire, ok, commit, start;
    logic [NCH-1:0] e_en, e_dv;
    @(posedge clk);
    n++;
    rl = pll_lock ? rl + 1 : 0;
    hist.push_back(rl);
    if (hist.size() > 3) void'(hist.pop_front());
    lk_new = (hist.size() == 3) && (hist[0] >= LCK);
    ok = (cfg_ratio != 0) && (cfg_duty != 0) &&
         (cfg_duty <= cfg_ratio) && (cfg_phase < cfg_ratio) &&
         (int'(cfg_ch) < NCH);
    fire = DYN && cfg_valid && !m_pend;
    commit = m_pend &&
             (!m_lk || pos(m_sch, n - 1) == m_r[m_sch] - 1);
    if (commit) begin
      m_r[m_sch] = m_sr;
      m_d[m_sch] = m_sd;
      m_p[m_sch] = m_sp;
      m_pend = 1'b0;
    end
    start = lk_new && (!m_lk || resync);
    for (int i = 0; i < NCH; i++) begin
      if (start) m_a[i] = n + m_p[i];
      else if (commit && i == m_sch) m_a[i] = n;
    end
    m_err = fire && !ok;
    if (fire && ok) begin
      m_pend = 1'b1;
      m_sch = int'(cfg_ch);
      m_sr = int'(cfg_ratio);
      m_sd = int'(cfg_duty);
      m_sp = int'(cfg_phase);
    end
    m_lk = lk_new;
    e_en = '0;
    e_dv = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_lk) begin
        e_en[i] = (pos(i, n) == 0);
        e_dv[i] = (pos(i, n) < m_d[i]);
      end
    end
    #1;
    chk("locked", int'(locked), int'(m_lk));
    chk("cfg_ready", int'(cfg_ready), int'(DYN && !m_pend));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("clk_en", int'(clk_en), int'(e_en));
    chk("clk_div", int'(clk_div), int'(e_dv));
  endtask

  task automatic set_req(int ch, int r, int d, int p);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_ratio = CW'(r);
    cfg_duty  = CW'(d);
    cfg_phase = CW'(p);
  endtask

  initial begin
    int k;
    tab[0]  = '{1'b0, 3'b101, 3'b101};
    tab[1]  = '{1'b0, 3'b100, 3'b101};
    tab[2]  = '{1'b0, 3'b100, 3'b100};
    tab[3]  = '{1'b0, 3'b110, 3'b110};
    tab[4]  = '{1'b0, 3'b100, 3'b100};
    tab[5]  = '{1'b0, 3'b101, 3'b101};
    tab[6]  = '{1'b0, 3'b100, 3'b101};
    tab[7]  = '{1'b0, 3'b110, 3'b110};
    tab[8]  = '{1'b0, 3'b100, 3'b100};
    tab[9]  = '{1'b0, 3'b100, 3'b100};
    tab[10] = '{1'b0, 3'b101, 3'b101};
    tab[11] = '{1'b0, 3'b110, 3'b111};
    tab[12] = '{1'b0, 3'b100, 3'b100};
    tab[13] = '{1'b1, 3'b101, 3'b101};
    tab[14] = '{1'b0, 3'b100, 3'b101};
    tab[15] = '{1'b0, 3'b100, 3'b100};
    tab[16] = '{1'b0, 3'b110, 3'b110};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_cfg_ready", int'(cfg_ready), int'(DYN));
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_clk_div", int'(clk_div), 0);
    rst_n = 1'b1;

    // Lock with a one-cycle glitch once the count has reached 10.
    pll_lock = 1'b1;
    repeat (12) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    k = 0;
    while (!locked && k < 40) begin
      step();
      k++;
    end
    chk("lock_latency_glitch", k, 18);

    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        resync = tab[i].rs;
        step();
      end
      chk("tab_en", int'(clk_en), int'(tab[i].en));
      chk("tab_div", int'(clk_div), int'(tab[i].dv));
    end
    resync = 1'b0;

`ifdef CLK_DIV_GEN_DYN_CFG_EN
    step();
    set_req(0, 3, 1, 0);
    step();
    cfg_valid = 1'b0;
    k = 0;
    while (!cfg_ready && k < 20) begin
      step();
      k++;
    end
    chk("upd_ready_wait", k, 5);
    chk("upd_first_en", int'(clk_en[0]), 1);
    repeat (3) step();
    chk("upd_period3_en", int'(clk_en[0]), 1);

    set_req(1, 5, 6, 0);
    step();
    cfg_valid = 1'b0;
    chk("rej_duty_err", int'(cfg_err), 1);
    step();
    chk("rej_duty_err_clr", int'(cfg_err), 0);
    set_req(3, 5, 2, 0);
    step();
    cfg_valid = 1'b0;
    chk("rej_ch_err", int'(cfg_err), 1);
    step();
    chk("rej_ch_err_clr", int'(cfg_err), 0);
`else
    set_req(0, 3, 1, 0);
    step();
    cfg_valid = 1'b0;
    chk("off_cfg_ready", int'(cfg_ready), 0);
    chk("off_cfg_err", int'(cfg_err), 0);
    repeat (6) step();
    chk("off_init_period", int'(clk_en[0]), 1);
`endif

    // Lock loss, then relock with realigned phases.
    pll_lock = 1'b0;
    k = 0;
    while (locked && k < 10) begin
      step();
      k++;
    end
    chk("unlock_latency", k, 3);
    chk("unlock_outs", int'({clk_en, clk_div}), 0);
    repeat (4) step();
    pll_lock = 1'b1;
    k = 0;
    while (!locked && k < 40) begin
      step();
      k++;
    end
    chk("relock_latency", k, 18);
    chk("relock_en0", int'(clk_en[0]), 1);
    chk("relock_en2", int'(clk_en[2]), 1);

    for (int c = 0; c < 3000; c++) begin
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_ratio = CW'($urandom_range(0, 7));
      cfg_duty  = CW'($urandom_range(0, 8));
      cfg_phase = CW'($urandom_range(0, 7));
      resync    = ($urandom_range(0, 30) == 0);
      if (pll_lock && $urandom_range(0, 400) == 0)
        pll_lock = 1'b0;
      else if (!pll_lock && $urandom_range(0, 5) == 0)
        pll_lock = 1'b1;
      step();
    end
    cfg_valid = 1'b0;
    resync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
